bit_packer_ctrl: RTL and testbench

BIT_PACKER_CTRL -- requirements
Module: bit_packer_ctrl

---
 rtl/bit_packer_pkg.sv | 19 +
 rtl/bit_packer_ctrl_bits2bytes.sv | 15 +
 rtl/bit_packer_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_bit_packer_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/bit_packer_pkg.sv
// Shared types and sizing helpers for the bit packer.
package bit_packer_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pk_state_e;

    function automatic int unsigned pk_beats(input int unsigned n_bytes, input int unsigned in_w);
        return (n_bytes * 8) / in_w;
    endfunction

    function automatic int unsigned pk_cnt_w(input int unsigned n_bytes, input int unsigned in_w);
        int unsigned b;
        b = pk_beats(n_bytes, in_w);
        return (b <= 1) ? 1 : $clog2(b);
    endfunction

endpackage

// File: rtl/bit_packer_ctrl_bits2bytes.sv
// Slices a flat word into an array of bytes, byte i = bits [i*8 +: 8].
module bits2bytes #(
    parameter int unsigned N_BYTES = 4
) (
    input  logic [N_BYTES*8-1:0]   bits_i,
    output logic [N_BYTES-1:0][7:0] bytes_o
);

    always_comb begin
        for (int unsigned i = 0; i < N_BYTES; i++) begin
            bytes_o[i] = bits_i[i*8 +: 8];
        end
    end

endmodule

// File: rtl/bit_packer_ctrl.sv
// Packs IN_W-bit beats LSB-first into N_BYTES-byte words with early close.
// Optional macro BIT_PACKER_SKID_EN adds a staging word so beats flow during HOLD.
module bit_packer_ctrl
    import bit_packer_pkg::*;
#(
    parameter int unsigned N_BYTES = 4,
    parameter int unsigned IN_W    = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [IN_W-1:0]         in_bits_i,
    input  logic                    in_last_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [N_BYTES-1:0][7:0] bytes_o,
    output logic                    out_last_o
);

    localparam int unsigned WORD_W = N_BYTES * 8;
    localparam int unsigned BEATS  = pk_beats(N_BYTES, IN_W);
    localparam int unsigned CW     = pk_cnt_w(N_BYTES, IN_W);
    localparam logic [CW-1:0] LAST_IDX = CW'(BEATS - 1);

    if (N_BYTES < 1 || N_BYTES > 64 || IN_W == 0 || (WORD_W % IN_W) != 0) begin : g_bad_cfg
        $error("bit_packer_ctrl: IN_W must divide N_BYTES*8 and N_BYTES must be 1..64");
    end

    function automatic logic [WORD_W-1:0] place(input logic [IN_W-1:0] b, input logic [CW-1:0] idx);
        return WORD_W'(b) << (IN_W * idx);
    endfunction

    pk_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              last_q, last_d;
    logic              accept;
    logic              out_hs;

    assign out_hs      = (state_q == HOLD) && out_ready_i;
    assign accept      = in_valid_i && in_ready_o;
    assign out_valid_o = (state_q == HOLD);
    assign out_last_o  = last_q;

`ifdef BIT_PACKER_SKID_EN
    logic [WORD_W-1:0] stg_q, stg_d;
    logic [CW-1:0]     scnt_q, scnt_d;
    logic              sfull_q, sfull_d;
    logic              slast_q, slast_d;

    assign in_ready_o = rst_ni && (!sfull_q || out_hs);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        last_d  = last_q;
        stg_d   = stg_q;
        scnt_d  = scnt_q;
        sfull_d = sfull_q;
        slast_d = slast_q;
        unique case (state_q)
            FILL: begin
                if (accept) begin
                    word_d = word_q | place(in_bits_i, cnt_q);
                    if (cnt_q == LAST_IDX || in_last_i) begin
                        state_d = HOLD;
                        last_d  = in_last_i;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (out_hs) begin
                    stg_d   = '0;
                    scnt_d  = '0;
                    sfull_d = 1'b0;
                    slast_d = 1'b0;
                    if (sfull_q) begin
                        // Complete staging word goes straight to output; new beat restarts staging.
                        word_d = stg_q;
                        last_d = slast_q;
                        cnt_d  = '0;
                        if (accept) begin
                            stg_d = place(in_bits_i, '0);
                            if (LAST_IDX == '0 || in_last_i) begin
                                sfull_d = 1'b1;
                                slast_d = in_last_i;
                            end else begin
                                scnt_d = CW'(1);
                            end
                        end
                    end else begin
                        // Partial staging becomes the word being filled.
                        state_d = FILL;
                        word_d  = stg_q;
                        cnt_d   = scnt_q;
                        last_d  = 1'b0;
                        if (accept) begin
                            word_d = stg_q | place(in_bits_i, scnt_q);
                            if (scnt_q == LAST_IDX || in_last_i) begin
                                state_d = HOLD;
                                last_d  = in_last_i;
                            end else begin
                                cnt_d = scnt_q + CW'(1);
                            end
                        end
                    end
                end else if (accept) begin
                    stg_d = stg_q | place(in_bits_i, scnt_q);
                    if (scnt_q == LAST_IDX || in_last_i) begin
                        sfull_d = 1'b1;
                        slast_d = in_last_i;
                    end else begin
                        scnt_d = scnt_q + CW'(1);
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stg_q   <= '0;
            scnt_q  <= '0;
            sfull_q <= 1'b0;
            slast_q <= 1'b0;
        end else begin
            stg_q   <= stg_d;
            scnt_q  <= scnt_d;
            sfull_q <= sfull_d;
            slast_q <= slast_d;
        end
    end
`else
    assign in_ready_o = rst_ni && (state_q == FILL);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        last_d  = last_q;
        unique case (state_q)
            FILL: begin
                if (accept) begin
                    word_d = word_q | place(in_bits_i, cnt_q);
                    if (cnt_q == LAST_IDX || in_last_i) begin
                        state_d = HOLD;
                        last_d  = in_last_i;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (out_ready_i) begin
                    state_d = FILL;
                    cnt_d   = '0;
                    word_d  = '0;
                    last_d  = 1'b0;
                end
            end
            default: state_d = FILL;
        endcase
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= FILL;
            cnt_q   <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            last_q  <= last_d;
        end
    end

    bits2bytes #(
        .N_BYTES(N_BYTES)
    ) u_bits2bytes (
        .bits_i (word_q),
        .bytes_o(bytes_o)
    );

endmodule

// File: tb/tb_bit_packer_ctrl.sv
// Randomized and directed bench for bit_packer_ctrl against a word-queue reference model.
module tb_bit_packer_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            v, l, ordy, ir, ov, ol;
    logic [7:0]      b;
    logic [3:0][7:0] by;

    logic            v1, b1, l1, r1, ir1, ov1, ol1;
    logic [3:0][7:0] by1;

    bit_packer_ctrl #(.N_BYTES(4), .IN_W(8)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(v), .in_ready_o(ir), .in_bits_i(b), .in_last_i(l),
        .out_valid_o(ov), .out_ready_i(ordy), .bytes_o(by), .out_last_o(ol)
    );

    bit_packer_ctrl #(.N_BYTES(4), .IN_W(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(v1), .in_ready_o(ir1), .in_bits_i(b1), .in_last_i(l1),
        .out_valid_o(ov1), .out_ready_i(r1), .bytes_o(by1), .out_last_o(ol1)
    );

    typedef struct packed {
        logic [31:0] w;
        logic        l;
    } word_t;

    word_t       q[$];
    logic [31:0] cur_w;
    int          cur_n;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        cur_w = '0;
        cur_n = 0;
    endtask

    // Drive one cycle (entered just after a falling edge), check outputs, advance model.
    task automatic cycle(input logic iv, input logic [7:0] ib, input logic il, input logic ordy_i);
        logic  exp_ov, exp_ir, acc;
        word_t nw;
        v = iv; b = ib; l = il; ordy = ordy_i;
        #1;
        exp_ov = (q.size() != 0);
`ifdef BIT_PACKER_SKID_EN
        exp_ir = (q.size() < 2) || ordy_i;
`else
        exp_ir = !exp_ov;
`endif
        check("out_valid", ov, exp_ov);
        check("in_ready", ir, exp_ir);
        if (exp_ov) begin
            check("bytes", by, q[0].w);
            check("out_last", ol, q[0].l);
        end
        acc = iv && exp_ir;
        if (exp_ov && ordy_i) void'(q.pop_front());
        if (acc) begin
            cur_w = cur_w | (32'(ib) << (cur_n * 8));
            cur_n++;
            if (cur_n == 4 || il) begin
                nw.w = cur_w;
                nw.l = il;
                q.push_back(nw);
                cur_w = '0;
                cur_n = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && (q.size() != 0); i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("drained", 64'(q.size()), 64'd0);
    endtask

    initial begin
        v = 0; b = 0; l = 0; ordy = 0;
        v1 = 0; b1 = 0; l1 = 0; r1 = 1;
        model_clear();
        @(negedge clk); @(negedge clk);
        #1;
        check("rst_valid", ov, 0);
        check("rst_ready", ir, 0);
        check("rst_bytes", by, 0);
        check("rst_last", ol, 0);
        rst_n = 1;
        @(negedge clk);

        // Full word, consumer ready
        cycle(1, 8'hEF, 0, 1); cycle(1, 8'hCD, 0, 1);
        cycle(1, 8'hAB, 0, 1); cycle(1, 8'h89, 0, 1);
        check("full_word", by, 32'h89ABCDEF);
        check("full_last", ol, 0);
        cycle(0, 8'h00, 0, 1);

        // Backpressure: word must stay stable
        cycle(1, 8'hEF, 0, 0); cycle(1, 8'hCD, 0, 0);
        cycle(1, 8'hAB, 0, 0); cycle(1, 8'h89, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 8'(8'h10 + i), 0, 0);
        check("stall_word", by, 32'h89ABCDEF);
        drain();

        // Early close
        cycle(1, 8'h11, 0, 1); cycle(1, 8'h22, 1, 1);
        check("early_word", by, 32'h00002211);
        check("early_last", ol, 1);
        cycle(0, 8'h00, 0, 1);

        // Reset mid-fill discards partial word
        cycle(1, 8'hAA, 0, 1); cycle(1, 8'hBB, 0, 1);
        rst_n = 0;
        #1;
        check("mid_rst_valid", ov, 0);
        check("mid_rst_ready", ir, 0);
        check("mid_rst_bytes", by, 0);
        check("mid_rst_last", ol, 0);
        @(posedge clk); @(negedge clk);
        rst_n = 1;
        model_clear();
        cycle(1, 8'h01, 0, 1); cycle(1, 8'h02, 0, 1);
        cycle(1, 8'h03, 0, 1); cycle(1, 8'h04, 0, 1);
        check("post_rst_word", by, 32'h04030201);
        cycle(0, 8'h00, 0, 1);

`ifdef BIT_PACKER_SKID_EN
        for (int i = 0; i < 4; i++) cycle(1, 8'(i), 0, 1);
        check("skid_word0", by, 32'h03020100);
        for (int i = 4; i < 8; i++) cycle(1, 8'(i), 0, 1);
        check("skid_word1", by, 32'h07060504);
        drain();
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(3) != 0), 8'($urandom), ($urandom_range(7) == 0),
                  ($urandom_range(4) > 1));
        end
        drain();

        // 1-bit beats, alternating 1,0
        for (int i = 0; i < 32; i++) begin
            v1 = 1; b1 = ((i % 2) == 0); l1 = 0; r1 = 1;
            #1;
            check("w1_ready", ir1, 1);
            @(posedge clk); @(negedge clk);
        end
        v1 = 0;
        #1;
        check("w1_valid", ov1, 1);
        check("w1_word", by1, 32'h55555555);
        check("w1_last", ol1, 0);
        @(posedge clk); @(negedge clk);
        #1;
        check("w1_released", ov1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
